cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among three result producers: ALU 1, ALU 2 and the load/store buffer.
- Each producer's result is captured into a one-entry holding buffer.
- One buffered result per cycle is granted round-robin and broadcast on a registered CDB to the reservation station, load/store buffer and ROB.
- Sits between the execution units and every tag-snooping consumer.

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_arbiter_rr_pick3.sv | 30 +++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encodings for the common data bus arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned REG_WIDTH = 32;
    localparam int unsigned ROB_WIDTH = 4;

    localparam logic [1:0] SRC_ALU_1 = 2'd0;
    localparam logic [1:0] SRC_ALU_2 = 2'd1;
    localparam logic [1:0] SRC_LSB   = 2'd2;

endpackage

// File: rtl/cdb_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: the first request at or after ptr (mod 3) wins.
module cdb_arbiter_rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o,
    output logic [1:0] gnt_idx_o,
    output logic       any_gnt_o
);

    logic [2:0] cand;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = {1'b0, ptr_i} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!any_gnt_o && req_i[cand[1:0]]) begin
                any_gnt_o         = 1'b1;
                gnt_idx_o         = cand[1:0];
                gnt_o[cand[1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// One-entry holding buffer per producer, round-robin grant, registered CDB broadcast.
module cdb_arbiter #(
    parameter int unsigned REG_WIDTH = cdb_arbiter_pkg::REG_WIDTH,
    parameter int unsigned ROB_WIDTH = cdb_arbiter_pkg::ROB_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 valid_alu_1,
    input  logic [REG_WIDTH-1:0] value_alu_1,
    input  logic [ROB_WIDTH-1:0] tag_alu_1,
    output logic                 ready_alu_1,
    input  logic                 valid_alu_2,
    input  logic [REG_WIDTH-1:0] value_alu_2,
    input  logic [ROB_WIDTH-1:0] tag_alu_2,
    output logic                 ready_alu_2,
    input  logic                 valid_lsb,
    input  logic [REG_WIDTH-1:0] value_lsb,
    input  logic [ROB_WIDTH-1:0] tag_lsb,
    output logic                 ready_lsb,
    output logic                 cdb_valid,
    output logic [REG_WIDTH-1:0] cdb_value,
    output logic [ROB_WIDTH-1:0] cdb_tag,
    output logic [1:0]           cdb_src
);

    import cdb_arbiter_pkg::*;

    logic [2:0]                in_valid;
    logic [2:0][REG_WIDTH-1:0] in_value;
    logic [2:0][ROB_WIDTH-1:0] in_tag;
    logic [2:0]                ready;

    logic [2:0]                buf_valid_d, buf_valid_q;
    logic [2:0][REG_WIDTH-1:0] buf_value_d, buf_value_q;
    logic [2:0][ROB_WIDTH-1:0] buf_tag_d, buf_tag_q;
    logic [1:0]                ptr_d, ptr_q;
    logic                      cdb_valid_d, cdb_valid_q;
    logic [REG_WIDTH-1:0]      cdb_value_d, cdb_value_q;
    logic [ROB_WIDTH-1:0]      cdb_tag_d, cdb_tag_q;
    logic [1:0]                cdb_src_d, cdb_src_q;

    logic [2:0]                gnt;
    logic [1:0]                gnt_idx;
    logic                      any_gnt;

    assign in_valid = {valid_lsb, valid_alu_2, valid_alu_1};
    assign in_value = {value_lsb, value_alu_2, value_alu_1};
    assign in_tag   = {tag_lsb, tag_alu_2, tag_alu_1};

    cdb_arbiter_rr_pick3 u_pick (
        .req_i     (buf_valid_q),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    // A buffer draining this cycle can accept a new result on the same edge.
    assign ready       = {3{rdy_in & ~flush}} & (~buf_valid_q | gnt);
    assign ready_alu_1 = ready[SRC_ALU_1];
    assign ready_alu_2 = ready[SRC_ALU_2];
    assign ready_lsb   = ready[SRC_LSB];

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_value_d = buf_value_q;
        buf_tag_d   = buf_tag_q;
        ptr_d       = ptr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_value_d = cdb_value_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        if (rdy_in) begin
            if (flush) begin
                buf_valid_d = '0;
                cdb_valid_d = 1'b0;
            end else begin
                if (any_gnt) begin
                    cdb_valid_d          = 1'b1;
                    cdb_value_d          = buf_value_q[gnt_idx];
                    cdb_tag_d            = buf_tag_q[gnt_idx];
                    cdb_src_d            = gnt_idx;
                    buf_valid_d[gnt_idx] = 1'b0;
                    ptr_d = (gnt_idx == SRC_LSB) ? SRC_ALU_1 : gnt_idx + 2'd1;
                end else begin
                    cdb_valid_d = 1'b0;
                end
                for (int unsigned i = 0; i < 3; i++) begin
                    if (in_valid[i] && ready[i]) begin
                        buf_valid_d[i] = 1'b1;
                        buf_value_d[i] = in_value[i];
                        buf_tag_d[i]   = in_tag[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            buf_valid_q <= '0;
            buf_value_q <= '0;
            buf_tag_q   <= '0;
            ptr_q       <= SRC_ALU_1;
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= SRC_ALU_1;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_value_q <= buf_value_d;
            buf_tag_q   <= buf_tag_d;
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_value_q <= cdb_value_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_value = cdb_value_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-free behavioural model.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        flush;
    logic [2:0]  in_v;
    logic [31:0] in_val [3];
    logic [3:0]  in_tag [3];
    logic        ready_alu_1, ready_alu_2, ready_lsb;
    logic        cdb_valid;
    logic [31:0] cdb_value;
    logic [3:0]  cdb_tag;
    logic [1:0]  cdb_src;

    int checks   = 0;
    int failures = 0;

    // Model state: three holding slots, rotating priority start, last broadcast.
    bit          m_bv   [3];
    int unsigned m_bval [3];
    int unsigned m_btag [3];
    int          m_ptr;
    bit          m_cv;
    int unsigned m_cval, m_ctag, m_csrc;
    bit   [2:0]  acc;

    always #5 clk = ~clk;

    cdb_arbiter dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .rdy_in      (rdy),
        .flush       (flush),
        .valid_alu_1 (in_v[0]),
        .value_alu_1 (in_val[0]),
        .tag_alu_1   (in_tag[0]),
        .ready_alu_1 (ready_alu_1),
        .valid_alu_2 (in_v[1]),
        .value_alu_2 (in_val[1]),
        .tag_alu_2   (in_tag[1]),
        .ready_alu_2 (ready_alu_2),
        .valid_lsb   (in_v[2]),
        .value_lsb   (in_val[2]),
        .tag_lsb     (in_tag[2]),
        .ready_lsb   (ready_lsb),
        .cdb_valid   (cdb_valid),
        .cdb_value   (cdb_value),
        .cdb_tag     (cdb_tag),
        .cdb_src     (cdb_src)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_bv[i] = 0; m_bval[i] = 0; m_btag[i] = 0;
        end
        m_ptr = 0; m_cv = 0; m_cval = 0; m_ctag = 0; m_csrc = 0;
    endtask

    function automatic int model_win();
        for (int k = 0; k < 3; k++) begin
            if (m_bv[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic bit exp_ready(input int i);
        return rdy && !flush && (!m_bv[i] || model_win() == i);
    endfunction

    task automatic model_step();
        int  w;
        bit  r [3];
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < 3; i++) m_bv[i] = 0;
            m_cv = 0;
            return;
        end
        w = model_win();
        for (int i = 0; i < 3; i++) r[i] = !m_bv[i] || (w == i);
        if (w >= 0) begin
            m_cv = 1; m_cval = m_bval[w]; m_ctag = m_btag[w]; m_csrc = w;
            m_bv[w] = 0;
            m_ptr = (w + 1) % 3;
        end else begin
            m_cv = 0;
        end
        for (int i = 0; i < 3; i++) begin
            if (in_v[i] && r[i]) begin
                m_bv[i] = 1; m_bval[i] = in_val[i]; m_btag[i] = in_tag[i];
            end
        end
    endtask

    // Called at posedge+1 with inputs already set: checks ready mid-cycle, then the
    // registered CDB just after the next edge.
    task automatic tick();
        logic [2:0] r;
        #1;
        r = {ready_lsb, ready_alu_2, ready_alu_1};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ready[%0d]", i), 32'(r[i]), 32'(exp_ready(i)));
            acc[i] = in_v[i] && exp_ready(i);
        end
        @(posedge clk);
        model_step();
        #1;
        chk("cdb_valid", 32'(cdb_valid), 32'(m_cv));
        chk("cdb_value", cdb_value, m_cval);
        chk("cdb_tag",   32'(cdb_tag), m_ctag);
        chk("cdb_src",   32'(cdb_src), m_csrc);
    endtask

    task automatic present(input int i, input int unsigned val, input int unsigned tag);
        in_v[i] = 1'b1; in_val[i] = val; in_tag[i] = 4'(tag);
    endtask

    task automatic idle_inputs();
        in_v = '0;
        for (int i = 0; i < 3; i++) begin in_val[i] = '0; in_tag[i] = '0; end
    endtask

    initial begin
        int prev_src;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; acc = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cdb_valid", 32'(cdb_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready_all", 32'({ready_lsb, ready_alu_2, ready_alu_1}), 32'h7);

        // Contention from ptr 0: tags 1/2/3 broadcast in source order.
        present(0, 32'h11, 1); present(1, 32'h22, 2); present(2, 32'h33, 3);
        tick();
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("cont_valid", 32'(cdb_valid), 32'd1);
            chk("cont_tag", 32'(cdb_tag), 32'(k + 1));
            chk("cont_src", 32'(cdb_src), 32'(k));
        end
        tick();

        // Single result.
        present(0, 32'h0000_00FF, 5);
        tick();
        idle_inputs();
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_value", cdb_value, 32'h0000_00FF);
        chk("single_tag", 32'(cdb_tag), 32'd5);
        chk("single_src", 32'(cdb_src), 32'd0);
        tick();
        chk("single_drop", 32'(cdb_valid), 32'd0);

        // Back-to-back refill on ALU 2.
        for (int k = 6; k <= 9; k++) begin
            if (k <= 8) present(1, 32'(k * 16), k);
            else idle_inputs();
            tick();
            if (k <= 8) chk("b2b_ready", 32'(acc[1]), 32'd1);
            if (k >= 7) chk("b2b_tag", 32'(cdb_tag), 32'(k - 1));
        end
        idle_inputs();
        tick();

        // Fairness: ALU 1 and LSB stream; grants must alternate.
        prev_src = -1;
        present(0, 32'h100, 0); present(2, 32'h200, 8);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (acc[0]) in_tag[0] = in_tag[0] + 4'd1;
            if (acc[2]) in_tag[2] = in_tag[2] + 4'd1;
            if (cdb_valid) begin
                if (prev_src >= 0) chk("fair_alternate", 32'(int'(cdb_src) != prev_src), 32'd1);
                prev_src = int'(cdb_src);
            end
        end
        idle_inputs();
        repeat (3) tick();

        // Flush with ALU 1 and LSB buffered.
        present(0, 32'hAAAA, 10); present(2, 32'hBBBB, 11);
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        chk("flush_ready", 32'({ready_lsb, ready_alu_2, ready_alu_1}), 32'd0);
        tick();
        chk("flush_valid", 32'(cdb_valid), 32'd0);
        flush = 1'b0;
        repeat (3) begin
            tick();
            chk("flush_no_stale", 32'(cdb_valid), 32'd0);
        end

        // Pause with tag 9 on the bus; ALU 2 presenting must not be captured.
        present(0, 32'h99, 9);
        tick();
        idle_inputs();
        tick();
        present(1, 32'h77, 7);
        rdy = 1'b0;
        repeat (3) begin
            tick();
            chk("pause_valid", 32'(cdb_valid), 32'd1);
            chk("pause_tag", 32'(cdb_tag), 32'd9);
            chk("pause_ready", 32'(acc), 32'd0);
        end
        rdy = 1'b1;
        idle_inputs();
        repeat (2) tick();

        // Asynchronous reset mid-cycle with a buffer still full.
        present(0, 32'h1, 3); present(2, 32'h2, 4);
        tick();
        idle_inputs();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(cdb_valid), 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        tick();
        chk("post_reset_ready", 32'({ready_lsb, ready_alu_2, ready_alu_1}), 32'h7);
        chk("post_reset_no_stale", 32'(cdb_valid), 32'd0);

        // Randomized traffic; producers hold data until accepted.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!in_v[i] || acc[i]) begin
                    in_v[i]   = ($urandom_range(0, 99) < 60);
                    in_val[i] = $urandom;
                    in_tag[i] = 4'($urandom_range(0, 15));
                end
            end
            rdy   = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 4);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
